// File: rtl/seg_display_sched.sv
// seg_display_sched: round-robin sharing of a 4-digit seven-segment display; define SEG_BLANK_LEADING_ZERO_EN to blank leading zeros
module seg_display_sched #(
  parameter int NUM_SRC = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_en,
  input  logic [NUM_SRC-1:0]     src_req,
  input  logic [NUM_SRC*16-1:0]  src_data,
  output logic [NUM_SRC-1:0]     src_ack,
  output logic [1:0]             cur_src,
  output logic [6:0]             led_segment,
  output logic [3:0]             anode_activate,
  output logic                   dp
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] disp_q;
  logic [1:0] rr_last, grant, pick;
  logic [DW-1:0] dwell;
  logic [PW-1:0] prescaler;
  logic [1:0] digit_idx;
  logic [3:0] nibble;
  logic [6:0] seg;
  // first requester after the last one served, wrapping round; descending loop lets the nearest win
  always_comb begin
    pick = rr_last;
    for (int i = NUM_SRC; i >= 1; i--)
      if (src_req[(int'(rr_last) + i) % NUM_SRC]) pick = 2'((int'(rr_last) + i) % NUM_SRC);
  end
  // arbiter next state and the ack, which is only given while the granted request is still up
  always_comb begin
    state_nx = state;
    src_ack = '0;
    if (state == IDLE && |src_req) state_nx = LOAD;
    if (state == LOAD) state_nx = src_req[grant] ? HOLD : IDLE;
    if (state == HOLD && dwell == '0) state_nx = IDLE;
    if (state == LOAD) src_ack[grant] = src_req[grant];
  end
  // arbiter state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // grant latch, snapshot of the served value and dwell countdown
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      disp_q <= '0;
      cur_src <= '0;
      rr_last <= 2'(NUM_SRC - 1);
      grant <= '0;
      dwell <= '0;
    end else begin
      if (state == IDLE) grant <= pick;
      if (state == LOAD && src_req[grant]) begin
        disp_q <= src_data[16*grant +: 16];
        cur_src <= grant;
        rr_last <= grant;
        dwell <= DW'(HOLD_CYCLES - 1);
      end else if (state == HOLD) dwell <= dwell - 1'b1;
    end
  // digit scan: prescaler wrap advances to the next digit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else begin
      prescaler <= prescaler == PW'(REFRESH_DIV - 1) ? '0 : prescaler + 1'b1;
      if (prescaler == PW'(REFRESH_DIV - 1)) digit_idx <= digit_idx + 1'b1;
    end
  assign nibble = disp_q[4*digit_idx +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
  assign seg = (digit_idx != 2'd0 && (disp_q >> (4*digit_idx)) == 16'h0) ? 7'h7F : HEX[nibble];
`else
  assign seg = HEX[nibble];
`endif
  // registered pin drivers so a digit never tears when the snapshot changes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      anode_activate <= 4'b1111;
      led_segment <= 7'h7F;
      dp <= 1'b1;
    end else begin
      anode_activate <= disp_en ? ~(4'b1 << digit_idx) : 4'b1111;
      led_segment <= seg;
      dp <= !(disp_en && digit_idx == cur_src);
    end
endmodule

// File: tb/tb_seg_display_sched.sv
// tb_seg_display_sched: vector tables, directed corner sequences and random traffic against a timeline model
module tb_seg_display_sched;
  localparam int NS = 4, R = 4, H = 8;
  logic clk = 0, rst_n = 0, disp_en = 1;
  logic [NS-1:0] src_req = '0;
  logic [NS*16-1:0] src_data = '0;
  logic [NS-1:0] src_ack;
  logic [1:0] cur_src;
  logic [6:0] led_segment;
  logic [3:0] anode_activate;
  logic dp;
  int total = 0, bad = 0;
  int t, c, pick_at, pend, mcur, mrr;
  logic [15:0] mdisp;
  logic [NS-1:0] dut_ack;
  bit auto_drop = 1;
  typedef struct { logic [15:0] data; logic [3:0][6:0] seg; } vec_t;
  vec_t vt [6];

  seg_display_sched #(.NUM_SRC(NS), .REFRESH_DIV(R), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en), .src_req(src_req), .src_data(src_data),
    .src_ack(src_ack), .cur_src(cur_src), .led_segment(led_segment),
    .anode_activate(anode_activate), .dp(dp));

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001; 4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010; 4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000; 4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001; 4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) return 7'h7F;
`endif
    return hexseg(v[4*d +: 4]);
  endfunction

  function automatic int search();
    for (int k = 1; k <= NS; k++) if (src_req[(mrr + k) % NS]) return (mrr + k) % NS;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input bit check);
    src_req = '0;
    rst_n = 0;
    #1;
    if (check) begin
      chk("rst_anode", anode_activate, 4'hF);
      chk("rst_seg", led_segment, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_ack", src_ack, 0);
      chk("rst_cur", cur_src, 0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    t = 0; c = 0; pick_at = 0; pend = -1; mdisp = 16'h0; mcur = 0; mrr = NS - 1;
  endtask

  task automatic step();
    logic [NS-1:0] ea;
    logic [3:0] ea_an;
    logic [15:0] v_b;
    int d, cur_b;
    bit en_b;
    ea = '0;
    #1;
    if (pend >= 0 && src_req[pend]) ea[pend] = 1'b1;
    dut_ack = src_ack;
    chk("ack", src_ack, ea);
    d = (c / R) % 4; en_b = disp_en; v_b = mdisp; cur_b = mcur;
    if (pend >= 0) begin
      if (ea != '0) begin
        mdisp = src_data[16*pend +: 16]; mcur = pend; mrr = pend; pick_at = t + H + 1;
      end else pick_at = t + 1;
      pend = -1;
    end else if (t >= pick_at && |src_req) pend = search();
    @(posedge clk);
    #1;
    t++; c++;
    ea_an = en_b ? ~(4'b1 << d) : 4'hF;
    chk("anode", anode_activate, ea_an);
    chk("seg", led_segment, exp_seg(v_b, d));
    chk("dp", dp, !(en_b && d == cur_b));
    chk("cur_src", cur_src, mcur);
    if (auto_drop) src_req = src_req & ~ea;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin step(); n++; end while (dut_ack == '0 && n < 40);
    chk(name, dut_ack != '0, 1'b1);
  endtask

  task automatic drive_random();
    for (int i = 0; i < NS; i++)
      if (!src_req[i]) begin
        if ($urandom_range(5) == 0) begin src_req[i] = 1'b1; src_data[16*i +: 16] = 16'($urandom); end
      end else if ($urandom_range(39) == 0) src_req[i] = 1'b0;
    if ($urandom_range(49) == 0) disp_en = ~disp_en;
  endtask

  initial begin
    int acks[$], ats[$];
    vt[0] = '{16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[1] = '{16'hFA80, {7'h0E, 7'h08, 7'h00, 7'h40}};
`ifdef SEG_BLANK_LEADING_ZERO_EN
    vt[2] = '{16'h0042, {7'h7F, 7'h7F, 7'h19, 7'h24}};
    vt[3] = '{16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
    vt[2] = '{16'h0042, {7'h40, 7'h40, 7'h19, 7'h24}};
    vt[3] = '{16'h0000, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif
    vt[4] = '{16'h5E9C, {7'h12, 7'h06, 7'h10, 7'h46}};
    vt[5] = '{16'hBD76, {7'h03, 7'h21, 7'h78, 7'h02}};
    do_reset(0);
    step();
    chk("first_digit_seg", led_segment, 7'h40);
    chk("first_digit_anode", anode_activate, 4'hE);
    for (int k = 0; k < 6; k++) begin
      logic [3:0][6:0] got;
      got = '1;
      src_data[15:0] = vt[k].data;
      src_req[0] = 1'b1;
      wait_ack("tbl_ack_seen");
      step();
      for (int n = 0; n < 4*R; n++) begin
        step();
        for (int j = 0; j < 4; j++) if (anode_activate == ~(4'b1 << j)) got[j] = led_segment;
      end
      for (int j = 0; j < 4; j++) chk($sformatf("tbl%0d_digit%0d", k, j), got[j], vt[k].seg[j]);
    end
    do_reset(0);
    auto_drop = 0;
    src_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
    src_req = '1;
    for (int n = 0; n < 100 && acks.size() < 6; n++) begin
      step();
      for (int i = 0; i < NS; i++) if (dut_ack[i]) begin acks.push_back(i); ats.push_back(t); end
    end
    chk("rr_count", acks.size(), 6);
    for (int i = 0; i < acks.size(); i++) begin
      chk("rr_order", acks[i], i % 4);
      if (i > 0) chk("rr_spacing", ats[i] - ats[i-1], 10);
    end
    auto_drop = 1;
    do_reset(1);
    src_data[47:32] = 16'hC0DE;
    src_req = 4'b0100;
    wait_ack("wd_first_ack");
    for (int n = 0; n < 12; n++) step();
    src_data[63:48] = 16'hBEEF;
    src_req = 4'b1000;
    step();
    src_req = '0;
    step();
    chk("wd_no_ack", dut_ack, 0);
    chk("wd_cur_kept", cur_src, 2);
    step();
    src_data[15:0] = 16'h0001;
    src_req = 4'b1001;
    wait_ack("wd_second_ack");
    chk("wd_next_grant", dut_ack, 4'b1000);
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
